gate_sweep_controller: RTL and testbench

Self-test sequencer for the two-input logic gate bank (and, or, not, xor, nand, nor, xnor). On a start request it drives the gate bank's a/b inputs through all four input combinations and waits a programmable settle time before each sample. It captures the seven gate outputs per combination into a 28-bit truth table and compares each sample against the golden values. It sits between a test/control host and one gate bank instance and reports pass/fail with a per-gate fault mask.

---
 rtl/gate_sweep_controller.sv | 118 +++++++++++
 tb/tb_gate_sweep_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_controller.sv
// Self-test sequencer for a two-input gate bank: walks a/b through all four
// combinations, samples the seven gate outputs and grades them against golden values.
module gate_sweep_controller #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        gate_a,
    output logic        gate_b,
    input  logic [6:0]  gate_y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [27:0] truth_table,
    output logic [6:0]  fail_mask
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [6:0]    acc;
    logic [6:0]    golden;
    logic [6:0]    diff;
    logic [4:0]    slot_base;

    // Golden word for the slot currently on the bank; bit order is
    // {xnor, nor, nand, xor, not(a), or, and}.
    always_comb begin
        golden = 7'h00;
        case (idx)
            2'd0: golden = 7'h74;
            2'd1: golden = 7'h1E;
            2'd2: golden = 7'h1A;
            2'd3: golden = 7'h43;
            default: golden = 7'h00;
        endcase
        diff      = gate_y ^ golden;
        slot_base = 5'(idx) * 5'd7;
    end

    // fail_mask/pass are published only at the end of the sweep; acc carries
    // the running mismatch flags until then.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 2'd0;
            cnt         <= '0;
            acc         <= 7'h00;
            gate_a      <= 1'b0;
            gate_b      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            truth_table <= 28'h0;
            fail_mask   <= 7'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    gate_a <= 1'b0;
                    gate_b <= 1'b0;
                    busy   <= 1'b0;
                    if (start) begin
                        truth_table <= 28'h0;
                        fail_mask   <= 7'h00;
                        pass        <= 1'b0;
                        acc         <= 7'h00;
                        idx         <= 2'd0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        state       <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    truth_table[slot_base +: 7] <= gate_y;
                    if (idx == 2'd3) begin
                        fail_mask <= acc | diff;
                        pass      <= ((acc | diff) == 7'h00);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        gate_a    <= 1'b0;
                        gate_b    <= 1'b0;
                        state     <= FINISH;
                    end else begin
                        acc              <= acc | diff;
                        idx              <= idx + 2'd1;
                        {gate_a, gate_b} <= idx + 2'd1;
                        state            <= DRIVE;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Bench for gate_sweep_controller: two instances (settle 1 and settle 3) driven by
// behavioural gate-bank models with injectable faults and output delay.
module tb_gate_sweep_controller;

    logic        clk;
    logic        rst;
    logic        start1, start2;
    logic        ga1, gb1, busy1, done1, pass1;
    logic        ga2, gb2, busy2, done2, pass2;
    logic [6:0]  gy1, gy2, fm1, fm2;
    logic [27:0] tt1, tt2;

    logic [6:0]  xm [4];
    logic [6:0]  om;
    int          dly;
    logic [1:0]  dl [8];
    logic        sel2;

    logic        o_busy, o_done, o_ga, o_gb, o_pass;
    logic [6:0]  o_fm;
    logic [27:0] o_tt;

    int total;
    int bad;

    gate_sweep_controller #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .gate_a(ga1), .gate_b(gb1),
        .gate_y(gy1), .busy(busy1), .done(done1), .pass(pass1),
        .truth_table(tt1), .fail_mask(fm1)
    );

    gate_sweep_controller #(.SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .gate_a(ga2), .gate_b(gb2),
        .gate_y(gy2), .busy(busy2), .done(done2), .pass(pass2),
        .truth_table(tt2), .fail_mask(fm2)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gate bank: {xnor, nor, nand, xor, not(a), or, and}
    function automatic logic [6:0] ideal(input logic a, input logic b);
        return {~(a ^ b), ~(a | b), ~(a & b), a ^ b, ~a, a | b, a & b};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) dl[i] <= 2'b00;
        end else begin
            dl[0] <= {ga2, gb2};
            for (int i = 1; i < 8; i++) dl[i] <= dl[i-1];
        end
    end

    always_comb begin
        logic [1:0] d;
        d   = dl[dly-1];
        gy1 = (ideal(ga1, gb1) ^ xm[{ga1, gb1}]) | om;
        gy2 = ideal(d[1], d[0]);
    end

    always_comb begin
        o_busy = sel2 ? busy2 : busy1;
        o_done = sel2 ? done2 : done1;
        o_ga   = sel2 ? ga2   : ga1;
        o_gb   = sel2 ? gb2   : gb1;
        o_pass = sel2 ? pass2 : pass1;
        o_fm   = sel2 ? fm2   : fm1;
        o_tt   = sel2 ? tt2   : tt1;
    end

    function automatic logic [27:0] ideal_table();
        logic [27:0] t;
        t = '0;
        for (int k = 0; k < 4; k++) t[7*k +: 7] = ideal(k[1], k[0]);
        return t;
    endfunction

    function automatic logic [27:0] faulty_table();
        logic [27:0] t;
        t = '0;
        for (int k = 0; k < 4; k++) t[7*k +: 7] = (ideal(k[1], k[0]) ^ xm[k]) | om;
        return t;
    endfunction

    // One full sweep with per-edge checking; pulses[n] is start before edge n.
    task automatic sweep(input logic use2, input logic [31:0] pulses, input logic [27:0] exp_tt);
        int          p;
        int          ix;
        logic [6:0]  exp_fail;
        logic [27:0] cap;
        logic        e_busy, e_done, e_ga, e_gb, e_pass;
        logic [6:0]  e_fm;
        p = use2 ? 4 : 2;
        sel2 = use2;
        exp_fail = 7'h00;
        for (int k = 0; k < 4; k++) exp_fail |= exp_tt[7*k +: 7] ^ ideal(k[1], k[0]);
        for (int n = 0; n <= 4*p + 2; n++) begin
            if (use2) start2 = pulses[n]; else start1 = pulses[n];
            @(posedge clk);
            @(negedge clk);
            cap = '0;
            for (int k = 0; k < 4; k++) if ((k + 1) * p <= n) cap[7*k +: 7] = exp_tt[7*k +: 7];
            ix     = n / p;
            e_busy = (n < 4*p);
            e_done = (n == 4*p);
            e_ga   = e_busy ? ix[1] : 1'b0;
            e_gb   = e_busy ? ix[0] : 1'b0;
            e_fm   = (n >= 4*p) ? exp_fail : 7'h00;
            e_pass = (n >= 4*p) ? (exp_fail == 7'h00) : 1'b0;
            total += 7;
            if (o_busy !== e_busy) begin bad++; $display("FAIL busy dut%0d edge=%0d got=%b exp=%b", use2 + 1, n, o_busy, e_busy); end
            if (o_done !== e_done) begin bad++; $display("FAIL done dut%0d edge=%0d got=%b exp=%b", use2 + 1, n, o_done, e_done); end
            if (o_ga !== e_ga) begin bad++; $display("FAIL gate_a dut%0d edge=%0d got=%b exp=%b", use2 + 1, n, o_ga, e_ga); end
            if (o_gb !== e_gb) begin bad++; $display("FAIL gate_b dut%0d edge=%0d got=%b exp=%b", use2 + 1, n, o_gb, e_gb); end
            if (o_tt !== cap) begin bad++; $display("FAIL truth_table dut%0d edge=%0d got=%h exp=%h", use2 + 1, n, o_tt, cap); end
            if (o_fm !== e_fm) begin bad++; $display("FAIL fail_mask dut%0d edge=%0d got=%h exp=%h", use2 + 1, n, o_fm, e_fm); end
            if (o_pass !== e_pass) begin bad++; $display("FAIL pass dut%0d edge=%0d got=%b exp=%b", use2 + 1, n, o_pass, e_pass); end
        end
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic clear_faults();
        for (int k = 0; k < 4; k++) xm[k] = 7'h00;
        om = 7'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 2;
        if ({ga1, gb1, busy1, done1, pass1, tt1, fm1} !== 40'h0) begin
            bad++; $display("FAIL reset_dut1 got=%h exp=0", {ga1, gb1, busy1, done1, pass1, tt1, fm1});
        end
        if ({ga2, gb2, busy2, done2, pass2, tt2, fm2} !== 40'h0) begin
            bad++; $display("FAIL reset_dut2 got=%h exp=0", {ga2, gb2, busy2, done2, pass2, tt2, fm2});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ideal();
        clear_faults();
        total++;
        if (ideal_table() !== 28'h8668F74) begin bad++; $display("FAIL model_table got=%h exp=8668f74", ideal_table()); end
        sweep(1'b0, 32'h1, ideal_table());
    endtask

    task automatic test_nor_stuck();
        clear_faults();
        om = 7'h20;
        sweep(1'b0, 32'h1, faulty_table());
        total++;
        if (fm1 !== 7'h20) begin bad++; $display("FAIL nor_stuck_mask got=%h exp=20", fm1); end
        clear_faults();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++)
                xm[k] = ($urandom_range(0, 2) == 0) ? 7'h00 : 7'($urandom_range(0, 127));
            om = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h00;
            sweep(1'b0, 32'h1, faulty_table());
        end
        clear_faults();
    endtask

    task automatic test_settle();
        logic [27:0] late;
        int prev;
        dly = 3;
        repeat (10) @(negedge clk);
        sweep(1'b1, 32'h1, ideal_table());
        dly = 4;
        repeat (10) @(negedge clk);
        // Four cycles late: each sample still sees the previous combination.
        late = '0;
        for (int k = 0; k < 4; k++) begin
            prev = (k == 0) ? 0 : k - 1;
            late[7*k +: 7] = ideal(prev[1], prev[0]);
        end
        sweep(1'b1, 32'h1, late);
        total++;
        if (pass2 !== 1'b0) begin bad++; $display("FAIL settle_late_pass got=%b exp=0", pass2); end
        dly = 3;
    endtask

    task automatic test_restart_ignored();
        clear_faults();
        sweep(1'b0, 32'h0000_0309, ideal_table());
    endtask

    task automatic test_reset_mid();
        clear_faults();
        sel2 = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        total++;
        if ({busy1, ga1, gb1} !== 3'b110) begin bad++; $display("FAIL mid_slot2_drive got=%b exp=110", {busy1, ga1, gb1}); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({ga1, gb1, busy1, done1, pass1, tt1, fm1} !== 40'h0) begin
            bad++; $display("FAIL mid_reset_outputs got=%h exp=0", {ga1, gb1, busy1, done1, pass1, tt1, fm1});
        end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (done1 !== 1'b0 || busy1 !== 1'b0) begin
                bad++; $display("FAIL mid_reset_quiet cycle=%0d done=%b busy=%b exp=0,0", c, done1, busy1);
            end
        end
        sweep(1'b0, 32'h1, ideal_table());
    endtask

    task automatic test_back_to_back();
        logic [27:0] exp_q[$];
        int done_at[$];
        clear_faults();
        for (int c = 0; c < 60; c++) begin
            start1 = (c < 40);
            @(posedge clk);
            @(negedge clk);
            if (c < 40 && (c % 10) == 0) exp_q.push_back(ideal_table());
            if (done1 === 1'b1) begin
                done_at.push_back(c);
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_unexpected_done cycle=%0d got=done exp=none", c);
                end else begin
                    logic [27:0] e;
                    e = exp_q.pop_front();
                    if (tt1 !== e || pass1 !== 1'b1 || fm1 !== 7'h00) begin
                        bad++; $display("FAIL b2b_result cycle=%0d got=%h/%b/%h exp=%h/1/00", c, tt1, pass1, fm1, e);
                    end
                end
            end
        end
        start1 = 1'b0;
        total++;
        if (done_at.size() != 4) begin bad++; $display("FAIL b2b_done_count got=%0d exp=4", done_at.size()); end
        for (int i = 1; i < done_at.size(); i++) begin
            total++;
            if (done_at[i] - done_at[i-1] != 10) begin
                bad++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=10", i, done_at[i] - done_at[i-1]);
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_missing_done got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        sel2   = 1'b0;
        dly    = 3;
        clear_faults();
        test_reset();
        test_ideal();
        test_nor_stuck();
        test_random();
        test_settle();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
